// File: rtl/south_rdata.sv
// AXI4 R-channel receiver: buffers one transfer's R beats in a FWFT FIFO and streams them to GTP TX.
// Latency: an accepted beat appears on gdma2gtp one cycle later; rready drops whenever the FIFO is full.

module south_rdata_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push is refused while full even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + 1'b1;
          empty <= 1'b0;
          full  <= (count == (AW+1)'(DEPTH-1));
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == (AW+1)'(1));
        end
        default: ;
      endcase
    end
  end
endmodule

module south_rdata #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [48:0] start_addr,
  input  logic [31:0] length,
  input  logic        op_start,
  input  logic        gdma_addr_done,
  output logic        gdma_done,
  input  logic [31:0] gdma_ddr_rdata,
  input  logic [1:0]  gdma_ddr_rresp,
  input  logic        gdma_ddr_rlast,
  input  logic        gdma_ddr_rvalid,
  output logic        gdma_ddr_rready,
  output logic [31:0] gdma2gtp_tdata,
  output logic        gdma2gtp_tlast,
  output logic        gdma2gtp_tvalid,
  input  logic        gdma2gtp_tready,
  output logic        rd_err,
  output logic        rlast_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [46:0] raddr_cnt;
  logic [7:0]  burst_cnt;
  logic [29:0] beat_cnt;
  logic [29:0] last_beat;
  logic        accept;
  logic        start;
  logic        k4_last;
  logic        burst_last;
  logic        data_last;
  logic        exp_rlast;
  logic        fifo_full;
  logic        fifo_empty;
  logic [32:0] head;
  logic        unused_lsbs;

  assign unused_lsbs = ^{start_addr[1:0], length[1:0]};

  assign start           = (state == IDLE) && op_start;
  assign gdma_ddr_rready = (state == RUN) && !fifo_full;
  assign accept          = gdma_ddr_rvalid && gdma_ddr_rready;

  assign k4_last    = (raddr_cnt[9:0] == 10'h3FF);
  assign burst_last = (burst_cnt == 8'hFF);
  assign data_last  = (beat_cnt == last_beat);
  assign exp_rlast  = k4_last || burst_last || data_last;

  south_rdata_fifo #(.W(33), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat ({data_last, gdma_ddr_rdata}),
    .pop      (gdma2gtp_tvalid && gdma2gtp_tready),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign gdma2gtp_tvalid = !fifo_empty;
  assign gdma2gtp_tdata  = head[31:0];
  assign gdma2gtp_tlast  = head[32] && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_start) state_nxt = RUN;
      RUN:     if (accept && data_last) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && gdma_addr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gdma_done <= 1'b1;
      rd_err    <= 1'b0;
      rlast_err <= 1'b0;
    end else if (start) begin
      gdma_done <= 1'b0;
      rd_err    <= 1'b0;
      rlast_err <= 1'b0;
    end else begin
      if (state == DRAIN && state_nxt == IDLE) gdma_done <= 1'b1;
      if (accept && (gdma_ddr_rlast != exp_rlast)) rlast_err <= 1'b1;
      if (accept && (gdma_ddr_rresp != 2'b00))     rd_err    <= 1'b1;
    end
  end

  // Transfer counters are only meaningful after a start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      raddr_cnt <= start_addr[48:2];
      burst_cnt <= '0;
      beat_cnt  <= '0;
      last_beat <= length[31:2];
    end else if (accept) begin
      raddr_cnt <= raddr_cnt + 1'b1;
      beat_cnt  <= beat_cnt + 1'b1;
      burst_cnt <= (k4_last || burst_last) ? 8'h00 : burst_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_south_rdata.sv
// Directed bench for south_rdata: drives R beats, sinks the stream and checks order, tlast and flags.
module tb_south_rdata;
  logic        clk = 1'b0;
  logic        rst;
  logic [48:0] start_addr;
  logic [31:0] length;
  logic        op_start;
  logic        gdma_addr_done;
  logic        gdma_done;
  logic [31:0] gdma_ddr_rdata;
  logic [1:0]  gdma_ddr_rresp;
  logic        gdma_ddr_rlast;
  logic        gdma_ddr_rvalid;
  logic        gdma_ddr_rready;
  logic [31:0] gdma2gtp_tdata;
  logic        gdma2gtp_tlast;
  logic        gdma2gtp_tvalid;
  logic        gdma2gtp_tready;
  logic        rd_err;
  logic        rlast_err;

  int errors = 0;
  int checks = 0;
  int run_id = 0;
  int acc_cnt;
  int rx_cnt;

  always #5 clk = ~clk;

  south_rdata #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_addr      (start_addr),
    .length          (length),
    .op_start        (op_start),
    .gdma_addr_done  (gdma_addr_done),
    .gdma_done       (gdma_done),
    .gdma_ddr_rdata  (gdma_ddr_rdata),
    .gdma_ddr_rresp  (gdma_ddr_rresp),
    .gdma_ddr_rlast  (gdma_ddr_rlast),
    .gdma_ddr_rvalid (gdma_ddr_rvalid),
    .gdma_ddr_rready (gdma_ddr_rready),
    .gdma2gtp_tdata  (gdma2gtp_tdata),
    .gdma2gtp_tlast  (gdma2gtp_tlast),
    .gdma2gtp_tvalid (gdma2gtp_tvalid),
    .gdma2gtp_tready (gdma2gtp_tready),
    .rd_err          (rd_err),
    .rlast_err       (rlast_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input int r, input int i);
    return 32'hA500_0000 + 32'(r) * 32'h0001_0000 + 32'(i);
  endfunction

  task automatic pulse_start(input logic [48:0] a, input logic [31:0] len);
    @(negedge clk);
    start_addr = a;
    length     = len;
    op_start   = 1'b1;
    @(negedge clk);
    op_start   = 1'b0;
  endtask

  // Offers n beats (rlast at rl0/rl1, SLVERR at resp_beat) while a sink holds tready low
  // for the first 'hold' cycles; op_at injects a stray op_start after that many accepts.
  task automatic do_xfer(input logic [48:0] a, input logic [31:0] len, input int n,
                         input int rl0, input int rl1, input int resp_beat,
                         input int hold, input bit late_done, input int op_at);
    int g;
    run_id++;
    acc_cnt = 0;
    rx_cnt  = 0;
    gdma_addr_done = !late_done;
    pulse_start(a, len);
    check("done_low", gdma_done, 1'b0);
    check("rd_err_clr", rd_err, 1'b0);
    check("rlast_err_clr", rlast_err, 1'b0);
    fork
      begin : drv
        int  guard;
        bit  rdy;
        bit  pulsed;
        guard  = 0;
        pulsed = 1'b0;
        while (acc_cnt < n && guard < 5000) begin
          guard++;
          gdma_ddr_rvalid = 1'b1;
          gdma_ddr_rdata  = data_of(run_id, acc_cnt);
          gdma_ddr_rlast  = (acc_cnt == rl0) || (acc_cnt == rl1);
          gdma_ddr_rresp  = (acc_cnt == resp_beat) ? 2'b10 : 2'b00;
          if (acc_cnt == op_at && !pulsed) begin
            op_start   = 1'b1;
            start_addr = 49'hFFC;
            length     = 32'h0;
            pulsed     = 1'b1;
          end else begin
            op_start = 1'b0;
          end
          rdy = gdma_ddr_rready;
          @(posedge clk);
          if (rdy) acc_cnt++;
          @(negedge clk);
        end
        op_start = 1'b0;
        if (guard >= 5000) check("drv_timeout", 64'(acc_cnt), 64'(n));
        check("rready_drain", gdma_ddr_rready, 1'b0);
        gdma_ddr_rvalid = 1'b0;
        gdma_ddr_rlast  = 1'b0;
        gdma_ddr_rresp  = 2'b00;
      end
      begin : snk
        int guard;
        guard = 0;
        while (rx_cnt < n && guard < 5000) begin
          guard++;
          gdma2gtp_tready = (guard > hold);
          if (hold > 0 && guard == hold + 1) begin
            check("acc_at_full", 64'(acc_cnt), 64'd16);
            check("rready_full", gdma_ddr_rready, 1'b0);
          end
          if (gdma2gtp_tvalid && gdma2gtp_tready) begin
            check("tdata", gdma2gtp_tdata, data_of(run_id, rx_cnt));
            check("tlast", gdma2gtp_tlast, rx_cnt == n - 1);
            if (rx_cnt == n - 1) check("done_before_pop", gdma_done, 1'b0);
            rx_cnt++;
          end
          @(negedge clk);
        end
        if (guard >= 5000) check("snk_timeout", 64'(rx_cnt), 64'(n));
        gdma2gtp_tready = 1'b1;
      end
    join
    check("tvalid_after", gdma2gtp_tvalid, 1'b0);
    if (late_done) begin
      repeat (5) @(negedge clk);
      check("done_waits_addr", gdma_done, 1'b0);
      gdma_addr_done = 1'b1;
    end
    g = 0;
    while (!gdma_done && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("done_high", gdma_done, 1'b1);
  endtask

  initial begin
    int g;
    rst             = 1'b1;
    start_addr      = '0;
    length          = '0;
    op_start        = 1'b0;
    gdma_addr_done  = 1'b1;
    gdma_ddr_rdata  = '0;
    gdma_ddr_rresp  = 2'b00;
    gdma_ddr_rlast  = 1'b0;
    gdma_ddr_rvalid = 1'b0;
    gdma2gtp_tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", gdma_done, 1'b1);
    check("rst_rready", gdma_ddr_rready, 1'b0);
    check("rst_tvalid", gdma2gtp_tvalid, 1'b0);
    check("rst_tlast", gdma2gtp_tlast, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    check("rst_rlast_err", rlast_err, 1'b0);

    // 256-beat burst, done held back until the AR side reports completion
    do_xfer(49'h0, 32'h3FC, 256, 255, -1, -1, 0, 1'b1, -1);
    check("t1_rlast_err", rlast_err, 1'b0);
    check("t1_rd_err", rd_err, 1'b0);

    // 4 KB split: 64 + 64, then wrong rlast placement
    do_xfer(49'hF00, 32'h1FC, 128, 63, 127, -1, 0, 1'b0, -1);
    check("t2_rlast_ok", rlast_err, 1'b0);
    do_xfer(49'hF00, 32'h1FC, 128, 62, 127, -1, 0, 1'b0, -1);
    check("t2_rlast_bad", rlast_err, 1'b1);
    check("t2_rd_err", rd_err, 1'b0);

    // backpressure: 20 beats with the stream stalled
    do_xfer(49'h0, 32'h4C, 20, 19, -1, -1, 40, 1'b0, -1);
    check("t3_rlast_err", rlast_err, 1'b0);

    // error response on beat 5, sticky to the end
    do_xfer(49'h40, 32'h1C, 8, 7, -1, 5, 0, 1'b0, -1);
    check("t4_rd_err", rd_err, 1'b1);
    check("t4_rlast_err", rlast_err, 1'b0);

    // reset in the middle of a 40-beat transfer
    run_id++;
    gdma_addr_done = 1'b1;
    pulse_start(49'h100, 32'h9C);
    gdma2gtp_tready = 1'b0;
    acc_cnt = 0;
    g = 0;
    while (acc_cnt < 10 && g < 200) begin
      bit rdy;
      g++;
      gdma_ddr_rvalid = 1'b1;
      gdma_ddr_rdata  = data_of(run_id, acc_cnt);
      gdma_ddr_rlast  = 1'b0;
      rdy = gdma_ddr_rready;
      @(posedge clk);
      if (rdy) acc_cnt++;
      @(negedge clk);
    end
    check("t5_accepted", 64'(acc_cnt), 64'd10);
    check("t5_tvalid_pre", gdma2gtp_tvalid, 1'b1);
    rst = 1'b1;
    gdma_ddr_rvalid = 1'b0;
    @(negedge clk);
    check("t5_tvalid", gdma2gtp_tvalid, 1'b0);
    check("t5_done", gdma_done, 1'b1);
    check("t5_rready", gdma_ddr_rready, 1'b0);
    rst = 1'b0;
    gdma2gtp_tready = 1'b1;
    do_xfer(49'h80, 32'h1C, 8, 7, -1, -1, 0, 1'b0, -1);
    check("t5_clean_rlast", rlast_err, 1'b0);
    check("t5_clean_rd", rd_err, 1'b0);

    // stray op_start during RUN must be ignored
    do_xfer(49'h200, 32'h1C, 8, 7, -1, -1, 0, 1'b0, 3);
    check("t6_rlast_err", rlast_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
